weight_fold_ctrl: RTL and testbench



---
 rtl/weight_fold_ctrl_if.sv | 38 +++
 rtl/weight_fold_ctrl.sv | 167 ++++++++++++++++
 tb/tb_weight_fold_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/weight_fold_ctrl_if.sv
// Bundle of the streaming load, sample/weight and RAM-port signals of weight_fold_ctrl.
// The controller uses the slave modport; the host/RAM side uses master.
interface weight_fold_ctrl_if #(
  parameter int AW = 12,
  parameter int DW = 14
) ();

  logic          cfg_start;
  logic          run_en;
  logic [DW-1:0] ld_data;
  logic          ld_valid;
  logic          ld_ready;
  logic          ld_done;
  logic          smp_valid;
  logic [DW-1:0] wt_data;
  logic          wt_valid;
  logic          wt_last;
  logic          busy;
  logic          drop_err;
  logic [AW-1:0] ram_w_addr;
  logic [DW-1:0] ram_w_data;
  logic          ram_w_en;
  logic [AW-1:0] ram_r_addr;
  logic [DW-1:0] ram_r_data;

  modport slave (
    input  cfg_start, run_en, ld_data, ld_valid, smp_valid, ram_r_data,
    output ld_ready, ld_done, wt_data, wt_valid, wt_last, busy, drop_err,
           ram_w_addr, ram_w_data, ram_w_en, ram_r_addr
  );

  modport master (
    output cfg_start, run_en, ld_data, ld_valid, smp_valid, ram_r_data,
    input  ld_ready, ld_done, wt_data, wt_valid, wt_last, busy, drop_err,
           ram_w_addr, ram_w_data, ram_w_en, ram_r_addr
  );

endinterface

// File: rtl/weight_fold_ctrl.sv
// Weight-fold RAM controller: streams coefficient loads into the RAM and sequences
// folded reads over a symmetric 2*DEPTH-tap window, keeping loads and readout exclusive.
module weight_fold_ctrl #(
  parameter int AW     = 12,
  parameter int DW     = 14,
  parameter int RD_LAT = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  weight_fold_ctrl_if.slave   bus_io
);

  localparam logic [AW:0]   K_LAST  = {(AW+1){1'b1}};
  localparam logic [AW-1:0] WA_LAST = {AW{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW:0]   winIdx_q, winIdx_d;
  logic [AW-1:0] wrAddr_q, wrAddr_d;
  logic          pend_q, pend_d;
  logic          dropErr_q, dropErr_d;

  logic          wEn_q;
  logic [AW-1:0] wAddr_q;
  logic [DW-1:0] wData_q;
  logic          ldDone_q;
  logic [AW-1:0] rAddr_q;
  logic [RD_LAT:0] vldPipe_q;
  logic [RD_LAT:0] lastPipe_q;

  logic          issue;
  logic          accept;
  logic          enterLoad;
  logic          dropSmp;
  logic          issueLast;
  logic [AW-1:0] foldAddr;

  // The upper half of the window mirrors the lower half: 2*DEPTH-1-k is the bitwise
  // inverse of k's low AW bits when the top bit is set.
  assign foldAddr  = winIdx_q[AW] ? ~winIdx_q[AW-1:0] : winIdx_q[AW-1:0];
  assign issueLast = issue && (winIdx_q == K_LAST);

  always_comb begin
    state_d   = state_q;
    winIdx_d  = winIdx_q;
    wrAddr_d  = wrAddr_q;
    issue     = 1'b0;
    accept    = 1'b0;
    enterLoad = 1'b0;
    dropSmp   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pend_q || bus_io.cfg_start) begin
          state_d   = LOAD;
          enterLoad = 1'b1;
          dropSmp   = bus_io.smp_valid;
        end else if (bus_io.smp_valid && bus_io.run_en) begin
          issue    = 1'b1;
          winIdx_d = winIdx_q + 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (bus_io.smp_valid) begin
          issue    = 1'b1;
          winIdx_d = winIdx_q + 1'b1;
          if (winIdx_q == K_LAST) begin
            if (pend_q || bus_io.cfg_start) begin
              state_d   = LOAD;
              enterLoad = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      LOAD: begin
        dropSmp = bus_io.smp_valid;
        if (bus_io.ld_valid) begin
          accept   = 1'b1;
          wrAddr_d = wrAddr_q + 1'b1;
          if (wrAddr_q == WA_LAST) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (enterLoad) begin
      wrAddr_d = '0;
    end
  end

  // A cfg_start that itself causes LOAD entry is consumed, not left pending.
  assign pend_d    = enterLoad ? 1'b0 : (pend_q | bus_io.cfg_start);
  assign dropErr_d = (dropErr_q & ~enterLoad) | dropSmp;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      winIdx_q  <= '0;
      wrAddr_q  <= '0;
      pend_q    <= 1'b0;
      dropErr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      winIdx_q  <= winIdx_d;
      wrAddr_q  <= wrAddr_d;
      pend_q    <= pend_d;
      dropErr_q <= dropErr_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wEn_q    <= 1'b0;
      wAddr_q  <= '0;
      wData_q  <= '0;
      ldDone_q <= 1'b0;
    end else begin
      wEn_q    <= accept;
      ldDone_q <= accept && (wrAddr_q == WA_LAST);
      if (accept) begin
        wAddr_q <= wrAddr_q;
        wData_q <= bus_io.ld_data;
      end
    end
  end

  // Valid/last ride alongside the RAM's address register and read latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rAddr_q    <= '0;
      vldPipe_q  <= '0;
      lastPipe_q <= '0;
    end else begin
      if (issue) begin
        rAddr_q <= foldAddr;
      end
      vldPipe_q  <= {vldPipe_q[RD_LAT-1:0], issue};
      lastPipe_q <= {lastPipe_q[RD_LAT-1:0], issueLast};
    end
  end

  assign bus_io.ld_ready   = (state_q == LOAD);
  assign bus_io.ld_done    = ldDone_q;
  assign bus_io.busy       = (state_q == LOAD) | pend_q;
  assign bus_io.drop_err   = dropErr_q;
  assign bus_io.ram_w_en   = wEn_q;
  assign bus_io.ram_w_addr = wAddr_q;
  assign bus_io.ram_w_data = wData_q;
  assign bus_io.ram_r_addr = rAddr_q;
  assign bus_io.wt_valid   = vldPipe_q[RD_LAT];
  assign bus_io.wt_last    = vldPipe_q[RD_LAT] & lastPipe_q[RD_LAT];
  // Gating keeps wt_data at zero in reset and between weights, since RAM output is not reset.
  assign bus_io.wt_data    = vldPipe_q[RD_LAT] ? bus_io.ram_r_data : '0;

endmodule

// File: tb/tb_weight_fold_ctrl.sv
// Self-checking bench for weight_fold_ctrl: a behavioural RAM plus a reference model
// of the load/readout rules, driven by directed phases with randomized data and gaps.
module tb_weight_fold_ctrl;

  localparam int AW     = 12;
  localparam int DW     = 14;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 1 << AW;
  localparam int WIN    = 2 * DEPTH;
  localparam int LAT    = 1 + RD_LAT;

  typedef struct { int due; logic [DW-1:0] data; logic last; } rdExp_t;
  typedef struct { int due; logic [AW-1:0] addr; logic [DW-1:0] data; } wrExp_t;
  typedef struct { logic [DW-1:0] data; logic last; } tap_t;

  logic clk = 1'b0;
  logic rst_n;

  weight_fold_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  weight_fold_ctrl #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  // Two-stage registered RAM: address at cycle n gives data at n+RD_LAT.
  logic [DW-1:0] ramMem [DEPTH];
  logic [DW-1:0] ramStage;
  always @(posedge clk) begin
    if (bus.ram_w_en === 1'b1) ramMem[bus.ram_w_addr] <= bus.ram_w_data;
    ramStage        <= ramMem[bus.ram_r_addr];
    bus.ram_r_data  <= ramStage;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rxCnt = 0;
  int doneCnt = 0;

  // Reference model: coefficient image, window contents and mode flags.
  logic [DW-1:0] refMem [DEPTH];
  tap_t   fq[$];
  rdExp_t expQ[$];
  wrExp_t wrQ[$];
  bit mLoading, mPend, mDrop, mActive;
  int mLoadCnt;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [DW-1:0] rndWord();
    return DW'($urandom);
  endfunction

  // A frame walks the stored image forward, then backward; the final tap is flagged.
  task automatic buildFrame();
    fq.delete();
    for (int i = 0; i < DEPTH; i++) fq.push_back('{data: refMem[i], last: 1'b0});
    for (int i = DEPTH - 1; i >= 0; i--) fq.push_back('{data: refMem[i], last: (i == 0)});
  endtask

  task automatic issueRead();
    tap_t t;
    t = fq.pop_front();
    expQ.push_back('{due: cyc + LAT, data: t.data, last: t.last});
  endtask

  task automatic observe();
    rdExp_t e;
    wrExp_t w;
    if (bus.ld_done === 1'b1) doneCnt++;
    if (expQ.size() > 0 && expQ[0].due == cyc) begin
      e = expQ.pop_front();
      if (bus.wt_valid === 1'b1) rxCnt++;
      checkOutput("wt_valid", 32'(bus.wt_valid), 1);
      checkOutput("wt_data", 32'(bus.wt_data), 32'(e.data));
      checkOutput("wt_last", 32'(bus.wt_last), 32'(e.last));
    end else begin
      checkOutput("wt_valid_quiet", 32'(bus.wt_valid), 0);
      checkOutput("wt_last_quiet", 32'(bus.wt_last), 0);
      checkOutput("wt_data_quiet", 32'(bus.wt_data), 0);
    end
    if (wrQ.size() > 0 && wrQ[0].due == cyc) begin
      w = wrQ.pop_front();
      checkOutput("ram_w_en", 32'(bus.ram_w_en), 1);
      checkOutput("ram_w_addr", 32'(bus.ram_w_addr), 32'(w.addr));
      checkOutput("ram_w_data", 32'(bus.ram_w_data), 32'(w.data));
      checkOutput("ld_done", 32'(bus.ld_done), 32'(w.addr == AW'(DEPTH - 1)));
    end else begin
      checkOutput("ram_w_en_quiet", 32'(bus.ram_w_en), 0);
      checkOutput("ld_done_quiet", 32'(bus.ld_done), 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    observe();
  endtask

  // One clock of stimulus: check the flag outputs, drive inputs, advance the model, clock.
  task automatic applyStimulus(input bit cfg, input bit run, input bit ldv,
                               input logic [DW-1:0] ldd, input bit smp);
    checkOutput("ld_ready", 32'(bus.ld_ready), 32'(mLoading));
    checkOutput("busy", 32'(bus.busy), 32'(mLoading | mPend));
    checkOutput("drop_err", 32'(bus.drop_err), 32'(mDrop));
    bus.cfg_start = cfg;
    bus.run_en    = run;
    bus.ld_valid  = ldv;
    bus.ld_data   = ldd;
    bus.smp_valid = smp;
    if (mLoading) begin
      if (ldv) begin
        wrQ.push_back('{due: cyc + 1, addr: AW'(mLoadCnt), data: ldd});
        refMem[mLoadCnt] = ldd;
        mLoadCnt++;
        if (mLoadCnt == DEPTH) begin
          mLoading = 1'b0;
          mLoadCnt = 0;
        end
      end
      if (smp) mDrop = 1'b1;
      if (cfg) mPend = 1'b1;
    end else if (mActive) begin
      if (smp) begin
        issueRead();
        if (fq.size() == 0) begin
          mActive = 1'b0;
          if (mPend || cfg) begin
            mLoading = 1'b1;
            mPend    = 1'b0;
            mDrop    = 1'b0;
          end
        end else if (cfg) begin
          mPend = 1'b1;
        end
      end else if (cfg) begin
        mPend = 1'b1;
      end
    end else begin
      if (mPend || cfg) begin
        mLoading = 1'b1;
        mPend    = 1'b0;
        mDrop    = smp;
      end else if (smp && run) begin
        buildFrame();
        mActive = 1'b1;
        issueRead();
      end
    end
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, '0, 0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_ld_ready", 32'(bus.ld_ready), 0);
    checkOutput("rst_ld_done", 32'(bus.ld_done), 0);
    checkOutput("rst_busy", 32'(bus.busy), 0);
    checkOutput("rst_drop_err", 32'(bus.drop_err), 0);
    checkOutput("rst_wt_valid", 32'(bus.wt_valid), 0);
    checkOutput("rst_wt_last", 32'(bus.wt_last), 0);
    checkOutput("rst_wt_data", 32'(bus.wt_data), 0);
    checkOutput("rst_ram_w_en", 32'(bus.ram_w_en), 0);
    checkOutput("rst_ram_w_addr", 32'(bus.ram_w_addr), 0);
    checkOutput("rst_ram_w_data", 32'(bus.ram_w_data), 0);
    checkOutput("rst_ram_r_addr", 32'(bus.ram_r_addr), 0);
    bus.cfg_start = 1'b0;
    bus.run_en    = 1'b0;
    bus.ld_valid  = 1'b0;
    bus.ld_data   = '0;
    bus.smp_valid = 1'b0;
    mLoading = 1'b0;
    mPend    = 1'b0;
    mDrop    = 1'b0;
    mActive  = 1'b0;
    mLoadCnt = 0;
    expQ.delete();
    wrQ.delete();
    fq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic loadWords(input bit gaps, input bit ramp);
    applyStimulus(1, 0, 0, '0, 0);
    for (int n = 0; n < 4 * DEPTH && mLoading; n++) begin
      bit v;
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      applyStimulus(0, 0, v, ramp ? DW'(mLoadCnt) : rndWord(), 0);
    end
    idle(3);
  endtask

  initial begin
    int base;
    bus.cfg_start = 1'b0;
    bus.run_en    = 1'b0;
    bus.ld_valid  = 1'b0;
    bus.ld_data   = '0;
    bus.smp_valid = 1'b0;
    rst_n = 1'b1;
    #2;
    doReset();
    idle(5);

    $display("[TB] ramp load, continuous ld_valid");
    base = doneCnt;
    loadWords(0, 1);
    checkOutput("ld_done_once_ramp", 32'(doneCnt - base), 1);

    $display("[TB] ramp load, toggling ld_valid");
    base = doneCnt;
    applyStimulus(1, 0, 0, '0, 0);
    for (int i = 0; i < 2 * DEPTH; i++) applyStimulus(0, 0, (i % 2 == 0), DW'(mLoadCnt), 0);
    idle(3);
    checkOutput("ld_done_once_toggle", 32'(doneCnt - base), 1);

    $display("[TB] strobes with run_en low are ignored");
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, '0, 1);

    $display("[TB] folded readout, back-to-back strobes");
    base = rxCnt;
    for (int i = 0; i < WIN; i++) applyStimulus(0, 1, 0, '0, 1);
    idle(5);
    checkOutput("frame_weight_count", 32'(rxCnt - base), 32'(WIN));

    $display("[TB] random image, then frame with reload requested at k=100");
    loadWords(1, 0);
    begin
      bit started, cfgSent;
      started = 1'b0;
      cfgSent = 1'b0;
      base = rxCnt;
      for (int n = 0; n < 6 * WIN; n++) begin
        bit s, c;
        s = ($urandom_range(0, 3) != 0);
        c = s && mActive && (WIN - fq.size() == 100) && !cfgSent;
        if (c) cfgSent = 1'b1;
        applyStimulus(c, mActive ? ($urandom_range(0, 1) == 1) : 1'b1,
                      ($urandom_range(0, 1) == 1), rndWord(), s);
        if (mActive) started = 1'b1;
        else if (started) break;
      end
      checkOutput("deferred_load_entered", 32'(bus.ld_ready), 1);
      checkOutput("deferred_busy", 32'(bus.busy), 1);
    end

    $display("[TB] strobes during load are dropped");
    for (int n = 0; n < 4 * DEPTH && mLoading; n++)
      applyStimulus(0, 1, ($urandom_range(0, 3) != 0), rndWord(),
                    (n == 0) || ($urandom_range(0, 7) == 0));
    idle(LAT + 2);
    checkOutput("frame_after_deferred", 32'(rxCnt - base), 32'(WIN));
    checkOutput("drop_err_set", 32'(bus.drop_err), 1);

    $display("[TB] frame on new image with drop_err held");
    base = rxCnt;
    for (int i = 0; i < WIN; i++) applyStimulus(0, 1, 0, '0, 1);
    idle(5);
    checkOutput("frame2_weight_count", 32'(rxCnt - base), 32'(WIN));
    checkOutput("drop_err_held", 32'(bus.drop_err), 1);

    $display("[TB] reset in the middle of a load");
    base = doneCnt;
    applyStimulus(1, 0, 0, '0, 0);
    checkOutput("drop_err_cleared", 32'(bus.drop_err), 0);
    for (int i = 0; i < 2000; i++) applyStimulus(0, 0, 1, rndWord(), 0);
    doReset();
    idle(5);
    checkOutput("no_ld_done_after_abort", 32'(doneCnt - base), 0);
    loadWords(0, 0);
    checkOutput("ld_done_once_fresh", 32'(doneCnt - base), 1);

    $display("[TB] asynchronous reset mid-frame");
    for (int i = 0; i < 60; i++) applyStimulus(0, 1, 0, '0, 1);
    checkOutput("pre_reset_wt_valid", 32'(bus.wt_valid), 1);
    doReset();
    idle(6);
    checkOutput("read_queue_drained", 32'(expQ.size()), 0);
    checkOutput("write_queue_drained", 32'(wrQ.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
